// File: rtl/bit_proc_core.sv
// 1-bit control processor core (MC14500 style): PC, JMP/halt sequencer, N_CH I/O channels.
// Optional single-step gating: define BIT_PROC_STEP_EN to add the `step` input.
module bit_proc_core #(
   parameter int ADDR_W = 4,
   parameter int N_CH   = 8
) (
   input  logic              clk,
   input  logic              rst,
`ifdef BIT_PROC_STEP_EN
   input  logic              step,
`endif
   output logic [ADDR_W-1:0] instr_addr,
   input  logic [7:0]        instr_data,
   input  logic [N_CH-1:0]   data_in,
   output logic [N_CH-1:0]   data_out,
   output logic              write,
   output logic              result,
   output logic              halted
);

   // state | meaning
   // EXEC  | execute the word at PC, one instruction per cycle
   // JTGT  | word at PC is the target of the preceding JMP
   // HALT  | stopped by HLT; only rst leaves this state
   typedef enum logic [1:0] {
      S_EXEC = 2'd0,
      S_JTGT = 2'd1,
      S_HALT = 2'd2
   } state_t;

   localparam logic [4:0] NCH5 = 5'(N_CH);

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic              rr;
   logic              ien;
   logic              oen;
   logic [3:0]        opc;
   logic [3:0]        op;
   logic              op_ok;
   logic [15:0]       din_ext;
   logic              in_bit;
   logic              adv;

   assign opc        = instr_data[7:4];
   assign op         = instr_data[3:0];
   assign op_ok      = {1'b0, op} < NCH5;
   assign din_ext    = 16'(data_in);
   assign in_bit     = ien & op_ok & din_ext[op];
   assign instr_addr = pc;
   assign result     = rr;

`ifdef BIT_PROC_STEP_EN
   assign adv = step;
`else
   assign adv = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_EXEC;
         pc       <= '0;
         rr       <= 1'b0;
         ien      <= 1'b1;
         oen      <= 1'b1;
         data_out <= '0;
         write    <= 1'b0;
         halted   <= 1'b0;
      end else begin
         write <= 1'b0;
         if (adv) begin
            case (state)
               S_EXEC: begin
                  pc <= pc + ADDR_W'(1);
                  case (opc)
                     4'h1: rr <= in_bit;
                     4'h2: rr <= ~in_bit;
                     4'h3: rr <= rr & in_bit;
                     4'h4: rr <= rr & ~in_bit;
                     4'h5: rr <= rr | in_bit;
                     4'h6: rr <= rr | ~in_bit;
                     4'h7: rr <= ~(rr ^ in_bit);
                     4'h8, 4'h9: begin
                        // stores to channels beyond N_CH are silently dropped
                        if (oen && op_ok) begin
                           write <= 1'b1;
                           for (int i = 0; i < N_CH; i++) begin
                              if (op == 4'(i)) data_out[i] <= (opc == 4'h8) ? rr : ~rr;
                           end
                        end
                     end
                     4'hA: ien <= in_bit;
                     4'hB: oen <= in_bit;
                     4'hC: state <= S_JTGT;
                     4'hD: if (!rr) pc <= pc + ADDR_W'(2);
                     4'hF: begin
                        pc     <= pc;
                        state  <= S_HALT;
                        halted <= 1'b1;
                     end
                     default: ;
                  endcase
               end
               S_JTGT: begin
                  pc    <= instr_data[ADDR_W-1:0];
                  state <= S_EXEC;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bit_proc_core.sv
// Self-checking bench for bit_proc_core: directed scenarios plus random programs against a behavioural model.
module tb_bit_proc_core;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] instr_addr;
   logic [7:0] instr_data;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       write, result, halted;
   logic [7:0] rom [16];

   int checks = 0;
   int errors = 0;

   // architectural model
   int         m_pc;
   bit         m_rr, m_ien, m_oen, m_wr, m_halt, m_jt;
   logic [7:0] m_out;

   always #5 clk = ~clk;
   assign instr_data = rom[instr_addr];

   bit_proc_core #(.ADDR_W(4), .N_CH(8)) dut (
      .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_data(instr_data),
      .data_in(data_in), .data_out(data_out), .write(write), .result(result), .halted(halted)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("pc", 32'(instr_addr), 32'(m_pc));
      chk("result", 32'(result), 32'(m_rr));
      chk("data_out", 32'(data_out), 32'(m_out));
      chk("write", 32'(write), 32'(m_wr));
      chk("halted", 32'(halted), 32'(m_halt));
   endtask

   task automatic model_step();
      logic [7:0] w;
      logic [3:0] opc, op;
      bit inb;
      int nxt;
      w   = rom[m_pc];
      opc = w[7:4];
      op  = w[3:0];
      inb = m_ien && (op < 8) && data_in[op[2:0]];
      m_wr = 0;
      if (m_halt) begin
      end else if (m_jt) begin
         m_pc = w % 16;
         m_jt = 0;
      end else begin
         nxt = (m_pc + 1) % 16;
         case (opc)
            1: m_rr = inb;
            2: m_rr = !inb;
            3: m_rr = m_rr && inb;
            4: m_rr = m_rr && !inb;
            5: m_rr = m_rr || inb;
            6: m_rr = m_rr || !inb;
            7: m_rr = (m_rr == inb);
            8, 9: if (m_oen && op < 8) begin
               m_out[op[2:0]] = (opc == 8) ? m_rr : !m_rr;
               m_wr = 1;
            end
            10: m_ien = inb;
            11: m_oen = inb;
            12: m_jt = 1;
            13: if (!m_rr) nxt = (m_pc + 2) % 16;
            15: begin m_halt = 1; nxt = m_pc; end
            default: ;
         endcase
         m_pc = nxt;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_pc = 0; m_rr = 0; m_ien = 1; m_oen = 1; m_wr = 0; m_halt = 0; m_jt = 0; m_out = 8'h00;
      check_all();
   endtask

   task automatic fill_rom(input logic [7:0] v);
      for (int i = 0; i < 16; i++) rom[i] = v;
   endtask

   initial begin
      int wcount;
      fill_rom(8'h00);

      // 1: LD 0, STO 1
      rom[0] = 8'h10; rom[1] = 8'h81;
      data_in = 8'h01;
      do_reset();
      wcount = 0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (write) wcount++;
      end
      chk("t1_wcount", 32'(wcount), 32'd1);
      chk("t1_out", 32'(data_out), 32'h02);
      chk("t1_result", 32'(result), 32'd1);

      // 2: OEN gating
      fill_rom(8'h00);
      rom[0] = 8'h12; rom[1] = 8'hB2; rom[2] = 8'h10; rom[3] = 8'h83;
      data_in = 8'h01;
      do_reset();
      wcount = 0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (write) wcount++;
      end
      chk("t2_wcount", 32'(wcount), 32'd0);
      chk("t2_out", 32'(data_out), 32'h00);

      // 3: JMP at 5 to 2
      fill_rom(8'h00);
      rom[0] = 8'h10; rom[5] = 8'hC0; rom[6] = 8'h02;
      data_in = 8'h01;
      do_reset();
      for (int i = 0; i < 5; i++) cycle();
      chk("t3_at5", 32'(instr_addr), 32'd5);
      cycle();
      chk("t3_at6", 32'(instr_addr), 32'd6);
      chk("t3_rr", 32'(result), 32'd1);
      cycle();
      chk("t3_at2", 32'(instr_addr), 32'd2);
      chk("t3_rr2", 32'(result), 32'd1);

      // 4: SKZ at 14 with RR=0, then RR=1
      fill_rom(8'h00);
      rom[14] = 8'hD0;
      do_reset();
      for (int i = 0; i < 15; i++) cycle();
      chk("t4_skz0", 32'(instr_addr), 32'd0);
      rom[0] = 8'h10;
      data_in = 8'h01;
      do_reset();
      for (int i = 0; i < 15; i++) cycle();
      chk("t4_skz1", 32'(instr_addr), 32'd15);
      cycle();
      chk("t4_wrap", 32'(instr_addr), 32'd0);

      // 5: HLT at 3
      fill_rom(8'h00);
      rom[3] = 8'hF0;
      do_reset();
      for (int i = 0; i < 4; i++) cycle();
      chk("t5_halted", 32'(halted), 32'd1);
      for (int i = 0; i < 10; i++) cycle();
      chk("t5_hold", 32'(instr_addr), 32'd3);
      do_reset();
      chk("t5_rst_pc", 32'(instr_addr), 32'd0);
      chk("t5_rst_h", 32'(halted), 32'd0);

      // 6: out-of-range channel, reset during JTGT
      fill_rom(8'h00);
      rom[0] = 8'h10; rom[1] = 8'h89; rom[2] = 8'h19;
      data_in = 8'hFF;
      do_reset();
      cycle();
      cycle();
      chk("t6_nowrite", 32'(write), 32'd0);
      chk("t6_out", 32'(data_out), 32'h00);
      cycle();
      chk("t6_ld9", 32'(result), 32'd0);
      fill_rom(8'h00);
      rom[0] = 8'hC0; rom[1] = 8'h07;
      do_reset();
      cycle();
      do_reset();
      chk("t6_jtgt_rst", 32'(instr_addr), 32'd0);
      cycle();
      chk("t6_jtgt_rst_next", 32'(instr_addr), 32'd1);

      // random programs
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
         data_in = 8'($urandom);
         do_reset();
         for (int c = 0; c < 40; c++) begin
            data_in = 8'($urandom);
            cycle();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
